pll_lock_supervisor: RTL and testbench

//  Reset/lock sequencer on the consuming side of the core PLLs. Drives the PLL reset, watches
//  the combined LOCKED indication, and releases the core reset only after lock is stable.

---
 rtl/pll_lock_supervisor_pkg.sv | 20 ++
 rtl/pll_lock_supervisor_sync.sv | 29 ++
 rtl/pll_lock_supervisor.sv | 146 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for PLL lock supervisors.
// Contents:
//   state_t      2-bit sequencer state
//   PLL_RST, WAIT_LOCK, STABLE, RUN   state encodings
//   sat_inc8()   8-bit increment that holds at 8'hFF
package pll_lock_supervisor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t PLL_RST   = 2'd0;
    localparam state_t WAIT_LOCK = 2'd1;
    localparam state_t STABLE    = 2'd2;
    localparam state_t RUN       = 2'd3;

    // Retry counter increment: sticks at all-ones instead of wrapping to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Generic 1-bit two-flop synchroniser, both flops cleared by reset.
// Ports:
//   clk_i  destination clock
//   rst_i  synchronous active-high reset
//   d_i    asynchronous input
//   q_o    synchronised output (two-cycle latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset / lock sequencer. Pulses the PLL reset, waits for a synchronised
// LOCKED, requires it to stay stable, then releases the core reset. Lock loss,
// lock timeout or a relock request in RUN restart the sequence.
// Runs on the free-running reference clock, never on a PLL output.
// Ports:
//   clk_sys       reference clock
//   reset         synchronous active-high; restarts the sequence
//   pll_locked    asynchronous combined PLL LOCKED
//   force_relock  one-cycle relock request, honoured only in RUN
//   pll_areset    PLL reset, high only in PLL_RST
//   sys_reset     core reset, high outside RUN
//   ready         high only in RUN
//   relock_count  saturating retry count since reset
//   timeout_err   sticky lock-timeout flag, cleared by reset only
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 20
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_areset,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic       timeout_err
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             lk;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       relock_q, relock_d;
    logic             terr_q, terr_d;
    logic             areset_q, areset_d;
    logic             sysrst_q, sysrst_d;
    logic             ready_q, ready_d;

    sync_2ff u_lock_sync (
        .clk_i (clk_sys),
        .rst_i (reset),
        .d_i   (pll_locked),
        .q_o   (lk)
    );

    // State, shared counter, status and registered outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= PLL_RST;
            cnt_q    <= '0;
            relock_q <= 8'd0;
            terr_q   <= 1'b0;
            areset_q <= 1'b1;
            sysrst_q <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            relock_q <= relock_d;
            terr_q   <= terr_d;
            areset_q <= areset_d;
            sysrst_q <= sysrst_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state logic; every decision uses the synchronised lock.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        relock_d = relock_q;
        terr_d   = terr_q;
        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d  = PLL_RST;
                    cnt_d    = '0;
                    terr_d   = 1'b1;
                    relock_d = sat_inc8(relock_q);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE: begin
                // A dropout restarts the lock wait without counting a retry.
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                // No glitch filtering: any synced-low cycle re-sequences.
                // Lock loss and a relock request together count once.
                if (!lk || force_relock) begin
                    state_d  = PLL_RST;
                    cnt_d    = '0;
                    relock_d = sat_inc8(relock_q);
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they register in step with it.
    always_comb begin
        areset_d = (state_d == PLL_RST);
        ready_d  = (state_d == RUN);
        sysrst_d = (state_d != RUN);
    end

    assign pll_areset   = areset_q;
    assign sys_reset    = sysrst_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    localparam int RC = 4;
    localparam int TO = 20;
    localparam int SC = 8;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_areset;
    logic       sys_reset;
    logic       ready;
    logic [7:0] relock_count;
    logic       timeout_err;

    pll_lock_supervisor #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (SC),
        .CNT_W         (8)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_areset   (pll_areset),
        .sys_reset    (sys_reset),
        .ready        (ready),
        .relock_count (relock_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic       ar;
        logic       sr;
        logic       rdy;
        logic [7:0] rc;
        logic       te;
    } out_t;

    out_t sb[$];

    // Reference model, advanced once per clock from the driven inputs.
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    int   m_st = 0;   // 0 reset pulse, 1 wait lock, 2 stable, 3 run
    int   m_cnt = 0;
    int   m_rc = 0;
    logic m_te = 1'b0;

    task automatic model_step();
        logic lk;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0; m_rc = 0; m_te = 0;
        end else begin
            lk = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            case (m_st)
                0: if (m_cnt == RC - 1) begin m_st = 1; m_cnt = 0; end
                   else m_cnt++;
                1: if (lk) begin m_st = 2; m_cnt = 0; end
                   else if (m_cnt == TO - 1) begin
                       m_st = 0; m_cnt = 0; m_te = 1;
                       if (m_rc < 255) m_rc++;
                   end else m_cnt++;
                2: if (!lk) begin m_st = 1; m_cnt = 0; end
                   else if (m_cnt == SC - 1) begin m_st = 3; m_cnt = 0; end
                   else m_cnt++;
                default: if (!lk || force_relock) begin
                       m_st = 0; m_cnt = 0;
                       if (m_rc < 255) m_rc++;
                   end
            endcase
        end
        sb.push_back('{ar: (m_st == 0), sr: (m_st != 3), rdy: (m_st == 3),
                       rc: 8'(m_rc), te: m_te});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One clock: model predicts, DUT advances, output compared with the queue head.
    task automatic step();
        out_t e, a;
        model_step();
        @(posedge clk_sys);
        #1;
        a = '{ar: pll_areset, sr: sys_reset, rdy: ready, rc: relock_count, te: timeout_err};
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("cycle_outputs", 32'(a), 32'(e));
        end
    endtask

    typedef struct {
        logic       rst;
        logic       lk;
        logic       frc;
        int         n;
        logic       e_ar;
        logic       e_rdy;
        logic [7:0] e_rc;
        logic       e_te;
        string      name;
    } seg_t;

    seg_t segs[$];

    initial begin
        int ar_cycles;
        int to_ready;
        // rst lk frc  n     ar rdy rc   te
        segs.push_back('{1, 1, 0, 1,    1, 0, 0,   0, "reset_state"});
        segs.push_back('{0, 1, 0, 3,    1, 0, 0,   0, "areset_held"});
        segs.push_back('{0, 1, 0, 1,    0, 0, 0,   0, "areset_released"});
        segs.push_back('{0, 1, 0, 8,    0, 0, 0,   0, "stable_not_ready"});
        segs.push_back('{0, 1, 0, 1,    0, 1, 0,   0, "first_run"});
        segs.push_back('{0, 1, 0, 5,    0, 1, 0,   0, "run_steady"});
        segs.push_back('{0, 0, 0, 1,    0, 1, 0,   0, "glitch_in_sync1"});
        segs.push_back('{0, 1, 0, 1,    0, 1, 0,   0, "glitch_in_sync2"});
        segs.push_back('{0, 1, 0, 1,    1, 0, 1,   0, "glitch_resequence"});
        segs.push_back('{0, 1, 0, 3,    1, 0, 1,   0, "relock_areset"});
        segs.push_back('{0, 1, 0, 1,    0, 0, 1,   0, "relock_wait"});
        segs.push_back('{0, 1, 0, 8,    0, 0, 1,   0, "relock_stable"});
        segs.push_back('{0, 1, 0, 1,    0, 1, 1,   0, "relock_run"});
        segs.push_back('{0, 1, 1, 1,    1, 0, 2,   0, "force_in_run"});
        segs.push_back('{0, 1, 0, 8,    0, 0, 2,   0, "stable_cnt3"});
        segs.push_back('{0, 0, 0, 1,    0, 0, 2,   0, "stable_drop_in"});
        segs.push_back('{0, 1, 0, 2,    0, 0, 2,   0, "stable_to_wait"});
        segs.push_back('{0, 1, 0, 8,    0, 0, 2,   0, "fresh_stable"});
        segs.push_back('{0, 1, 0, 1,    0, 1, 2,   0, "fresh_run"});
        segs.push_back('{0, 0, 0, 2,    0, 1, 2,   0, "loss_pipeline"});
        segs.push_back('{0, 0, 1, 1,    1, 0, 3,   0, "loss_and_force_once"});
        segs.push_back('{0, 0, 0, 4,    0, 0, 3,   0, "into_wait"});
        segs.push_back('{0, 0, 1, 1,    0, 0, 3,   0, "force_in_wait_ignored"});
        segs.push_back('{0, 0, 0, 18,   0, 0, 3,   0, "wait_before_timeout"});
        segs.push_back('{0, 0, 0, 1,    1, 0, 4,   1, "timeout_retry"});
        segs.push_back('{0, 0, 0, 4,    0, 0, 4,   1, "mid_wait"});
        segs.push_back('{1, 0, 0, 1,    1, 0, 0,   0, "reset_mid_wait"});
        segs.push_back('{0, 0, 0, 23,   0, 0, 0,   0, "no_lock_first_window"});
        segs.push_back('{0, 0, 0, 1,    1, 0, 1,   1, "first_timeout"});
        segs.push_back('{0, 0, 0, 6096, 1, 0, 255, 1, "saturate_255"});
        segs.push_back('{0, 0, 0, 24,   1, 0, 255, 1, "no_wrap"});
        segs.push_back('{0, 0, 0, 21,   0, 0, 255, 1, "wait_cnt17"});
        segs.push_back('{0, 1, 0, 3,    0, 0, 255, 1, "lock_beats_timeout"});
        segs.push_back('{1, 1, 0, 1,    1, 0, 0,   0, "final_reset"});

        foreach (segs[i]) begin
            reset        = segs[i].rst;
            pll_locked   = segs[i].lk;
            force_relock = segs[i].frc;
            for (int k = 0; k < segs[i].n; k++) step();
            check({segs[i].name, ".pll_areset"}, 32'(pll_areset), 32'(segs[i].e_ar));
            check({segs[i].name, ".ready"},      32'(ready),      32'(segs[i].e_rdy));
            check({segs[i].name, ".sys_reset"},  32'(sys_reset),  32'(!segs[i].e_rdy));
            check({segs[i].name, ".relock"},     32'(relock_count), 32'(segs[i].e_rc));
            check({segs[i].name, ".timeout"},    32'(timeout_err),  32'(segs[i].e_te));
        end

        // Hand sequence: after reset with lock present, count the PLL reset
        // pulse width and the cycles until ready rises.
        reset = 1'b0;
        pll_locked = 1'b1;
        force_relock = 1'b0;
        ar_cycles = 1;   // the reset cycle itself drives pll_areset high
        to_ready = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (pll_areset) ar_cycles++;
            if (ready && to_ready == 0) to_ready = k + 1;
        end
        check("areset_pulse_width", 32'(ar_cycles), 32'(RC));
        check("cycles_to_ready", 32'(to_ready), 32'(RC + 1 + SC));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
